// File: rtl/icache_ctrl_if.sv
// rtl/icache_ctrl_if.sv - fetch, invalidate and memory-read signals of the icache controller
interface icache_ctrl_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inv_req;
    logic        inv_done;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ready;
    logic        ret_valid;
    logic [31:0] ret_data;

    modport master (
        output req_valid, req_addr, inv_req, rd_ready, ret_valid, ret_data,
        input  req_ready, resp_valid, resp_data, inv_done, rd_req, rd_addr
    );

    modport slave (
        input  req_valid, req_addr, inv_req, rd_ready, ret_valid, ret_data,
        output req_ready, resp_valid, resp_data, inv_done, rd_req, rd_addr
    );
endinterface

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped icache controller sequencing external tag and data BRAMs
module icache_ctrl #(
    parameter int INDEX_WIDTH  = 8,
    parameter int OFFSET_WIDTH = 4,
    parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    icache_ctrl_if.slave           bus,
    output logic [INDEX_WIDTH-1:0] tag_addr,
    output logic [TAG_WIDTH:0]     tag_din,
    output logic                   tag_we,
    input  logic [TAG_WIDTH:0]     tag_dout,
    output logic [INDEX_WIDTH-1:0] data_addr,
    output logic [127:0]           data_din,
    output logic                   data_we,
    input  logic [127:0]           data_dout
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_WRITE, S_INV
    } state_t;

    state_t                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
    logic [1:0]             off_q, off_d;
    logic [1:0]             beat_q, beat_d;
    logic [127:0]           line_q, line_d;

    logic [TAG_WIDTH-1:0]   req_tag;
    logic [INDEX_WIDTH-1:0] req_index;
    logic [1:0]             req_off;
    logic                   hit;
    logic                   accept;
    logic                   unused_addr_bits;

    assign req_tag          = bus.req_addr[31 -: TAG_WIDTH];
    assign req_index        = bus.req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_off          = bus.req_addr[3:2];
    assign unused_addr_bits = ^bus.req_addr[1:0];

    // tag_dout reflects the index presented in the acceptance cycle
    assign hit = (state_q == S_LOOKUP) && tag_dout[TAG_WIDTH]
                 && (tag_dout[TAG_WIDTH-1:0] == tag_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            index_q <= '0;
            sweep_q <= '0;
            off_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            index_q <= index_d;
            sweep_q <= sweep_d;
            off_q   <= off_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        tag_d          = tag_q;
        index_d        = index_q;
        sweep_d        = sweep_q;
        off_d          = off_q;
        beat_d         = beat_q;
        line_d         = line_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.inv_done   = 1'b0;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        tag_we         = 1'b0;
        tag_din        = '0;
        data_we        = 1'b0;
        data_din       = '0;

        bus.req_ready = ((state_q == S_IDLE) && !bus.inv_req) || hit;
        accept        = bus.req_valid && bus.req_ready;

        if (accept) begin
            tag_d   = req_tag;
            index_d = req_index;
            off_d   = req_off;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.inv_req) begin
                    state_d = S_INV;
                end else if (accept) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_data  = data_dout[{off_q, 5'b0} +: 32];
                    state_d        = accept ? S_LOOKUP : S_IDLE;
                end else begin
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
                if (bus.rd_ready) begin
                    state_d = S_REFILL;
                    beat_d  = 2'd0;
                end
            end
            S_REFILL: begin
                if (bus.ret_valid) begin
                    line_d[{beat_q, 5'b0} +: 32] = bus.ret_data;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                tag_we         = 1'b1;
                data_we        = 1'b1;
                tag_din        = {1'b1, tag_q};
                data_din       = line_q;
                bus.resp_valid = 1'b1;
                bus.resp_data  = line_q[{off_q, 5'b0} +: 32];
                state_d        = S_IDLE;
            end
            S_INV: begin
                tag_we  = 1'b1;
                sweep_d = sweep_q + INDEX_WIDTH'(1);
                if (&sweep_q) begin
                    bus.inv_done = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Index comes straight from the request whenever one may be accepted
        if (bus.req_ready) begin
            tag_addr = req_index;
        end else if (state_q == S_INV) begin
            tag_addr = sweep_q;
        end else begin
            tag_addr = index_q;
        end
        data_addr = tag_addr;
    end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction-cache controller that sequences one tag/valid single-port BRAM and one line-data single-port BRAM.
- Both BRAMs are write-first with 1-cycle read latency; the controller instantiates neither.
- Serves the fetch stage with pipelined hits, refills missing lines from the memory read interface, and supports invalidate-all by sweeping the tag RAM.

Parameters:
INDEX_WIDTH, 8, line index bits; 256 lines
OFFSET_WIDTH, 4, byte offset bits; 16-byte line, 4 words (fixed, not varied by bench)
TAG_WIDTH, 32-INDEX_WIDTH-OFFSET_WIDTH, tag bits (derived)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  fetch request
req_addr  in  32  fetch byte address; bits [1:0] ignored
req_ready  out  1  request accepted when req_valid&&req_ready
resp_valid  out  1  one-cycle response pulse
resp_data  out  32  instruction word
inv_req  in  1  invalidate-all request, level, sampled in IDLE
inv_done  out  1  pulse on last sweep write
rd_req  out  1  line read request, held until rd_ready
rd_addr  out  32  line-aligned address {tag,index,4'b0}
rd_ready  in  1  memory accepts rd_req
ret_valid  in  1  return beat valid
ret_data  in  32  return word, beat 0 = word 0
tag_addr  out  INDEX_WIDTH  tag RAM address
tag_din  out  TAG_WIDTH+1  {valid,tag}
tag_we  out  1  tag RAM write enable
tag_dout  in  TAG_WIDTH+1  tag RAM read data, 1-cycle latency
data_addr  out  INDEX_WIDTH  data RAM address; always equals tag_addr
data_din  out  128  line, word i at [32i+31:32i]
data_we  out  1  data RAM write enable
data_dout  in  128  data RAM read data, 1-cycle latency

Behaviour:
- Reset: state IDLE; beat counter and sweep counter 0; all registered outputs 0. RAM contents are untouched.
- States: IDLE, LOOKUP, MISS, REFILL, WRITE, INV.
- req_ready:
  - 1 in IDLE when inv_req=0.
  - 1 in LOOKUP when the current lookup hits.
  - 0 otherwise.
- RAM address mux:
  - When req_ready=1: index from req_addr (combinational).
  - INV: sweep counter.
  - All other states: registered index.
- Acceptance: registers tag, index and word offset (addr[3:2]); next state LOOKUP.
- LOOKUP, hit (tag_dout valid bit=1 and tag equal):
  - resp_valid=1, resp_data=data_dout word[offset] in this cycle. Request-to-response latency is 1 cycle.
  - If a new request is accepted in the same cycle, stay in LOOKUP; else go to IDLE.
  - Back-to-back hits sustain 1 per cycle.
- LOOKUP, miss: no response; go to MISS.
- MISS:
  - rd_req=1 and rd_addr stable until rd_ready=1.
  - On the handshake cycle, go to REFILL with beat count 0.
- REFILL:
  - Each ret_valid stores ret_data into line buffer word[count], then count+1.
  - The 4th beat goes to WRITE. There is no last-beat signal; ret_valid outside REFILL is ignored.
- WRITE (1 cycle):
  - tag_we=data_we=1 at the registered index; tag_din={1,tag}, data_din=line buffer.
  - resp_valid=1, resp_data=buffer word[offset].
  - Next state IDLE; no request is accepted in this cycle.
- INV:
  - Entered from IDLE when inv_req=1. inv_req has priority over req_valid in the same cycle; req_ready=0.
  - Each cycle writes tag_we=1, tag_din=0 at the sweep counter, then counter+1.
  - At counter=2^INDEX_WIDTH-1: inv_done=1, counter wraps to 0, go to IDLE.
  - data_we=0 throughout INV.
- Write-first RAMs: a request to a just-refilled line accepted the cycle after WRITE hits with the new data.
- Reset mid-operation:
  - An outstanding rd_req drops immediately.
  - A partial refill is discarded and no RAM write occurs.
  - Return beats arriving after reset are ignored.
  - A partial sweep leaves the remaining lines valid; software reissues invalidate.
- Address/width rules:
  - tag = addr[31:12], index = addr[11:4] at default parameters.
  - Counters are sized INDEX_WIDTH and 2 bits and wrap naturally.

Test Plan:
- Cold miss, addr 0x0000_1008, rd_ready=1 next cycle, beats 0xA0..0xA3 -> rd_addr=0x0000_1000; WRITE cycle tag_din={1,0x00001} at index 0x00; resp_data=0xA2.
- Hits at 0x1000, 0x1004, 0x100C on consecutive cycles after that refill -> req_ready stays 1, resp 0xA0, 0xA1, 0xA3 on consecutive cycles, no rd_req.
- Conflict: after the refill, addr 0x0000_2000 (same index 0x00, tag 0x00002) -> miss, rd_addr=0x2000, tag overwritten; a following 0x1000 misses again.
- inv_req=1 and req_valid=1 in the same IDLE cycle -> req_ready=0, 256 tag writes of 0 at addresses 0..255, inv_done on the 256th; then 0x1000 misses.
- rd_ready held 0 for 5 cycles -> rd_req=1 and rd_addr stable all 5 cycles; a spurious ret_valid during MISS is ignored.
- rst asserted after 2 of 4 beats -> outputs 0 at once; tag_we never pulses; the same address re-requested later produces a fresh miss.
